uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16: clk cycles per bit; legal range 4..65535; even values only.
REQ-002 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-003 SHALL have port n_rst, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port rx, input, 1: asynchronous serial line, idle high.
REQ-005 SHALL have port rx_byte, output, 8: last correctly framed byte, held until the next one.
REQ-006 SHALL have port received, output, 1: one-cycle pulse when rx_byte updates.
REQ-007 SHALL have port is_receiving, output, 1: high in every state except IDLE.
REQ-008 SHALL have port recv_error, output, 1: one-cycle pulse on a framing error (or a parity error, see REQ-021).

Function
REQ-009 SHALL pass rx through a two-flop synchronizer (reset value 1); all logic uses the synchronized signal rxs.
REQ-010 SHALL implement these states: IDLE, START, DATA, [PARITY], STOP, WAIT_HIGH.
REQ-011 SHALL move IDLE->START on a 1->0 transition of rxs and load the bit counter with CLK_DIV/2-1.
REQ-012 SHALL sample rxs at bit-counter zero in START.
- Sample 0: go to DATA with counter = CLK_DIV-1.
- Sample 1 (glitch): return to IDLE; no error, no pulse.
REQ-013 SHALL, in DATA, sample 8 bits LSB-first, one per CLK_DIV cycles, into a shift register; the index wraps 7->0 on exit to STOP (or PARITY).
REQ-014 SHALL sample the stop bit in STOP.
- Sample 1: copy the shift register to rx_byte, pulse received in the next cycle, go to IDLE.
- Sample 0: pulse recv_error, leave rx_byte unchanged, go to WAIT_HIGH.
REQ-015 SHALL stay in WAIT_HIGH while rxs=0 (break), then go to IDLE once rxs=1; a new start bit is only recognized from IDLE.
REQ-016 SHALL never assert received and recv_error in the same cycle.
REQ-017 SHALL assert received exactly CLK_DIV/2 + 9*CLK_DIV + 1 cycles after the rxs falling edge (153 for CLK_DIV=16, no parity).
REQ-018 SHALL accept back-to-back frames: a start edge arriving in the cycle IDLE is re-entered is detected.

Reset
REQ-019 SHALL, while n_rst=0 (including mid-frame), force:
- state to IDLE
- rx_byte to 8'h00
- received, recv_error and is_receiving to 0
- synchronizer flops to 1
- counters to 0
REQ-020 SHALL, after reset releases with rx low, not detect a start until rxs has been seen high.

Configuration
REQ-021 SHALL support macro UART_RX_PARITY_EN.
- Defined: add a PARITY state after DATA that samples one even-parity bit. A mismatch pulses recv_error and goes to STOP-skip WAIT_HIGH handling as for a framing error; rx_byte is not updated. received latency becomes CLK_DIV/2 + 10*CLK_DIV + 1.
- Undefined: no PARITY state and no parity logic; the frame is 8N1.

Structure
REQ-022 SHALL place the state enum and the constants DATA_BITS=8 and IDLE_LEVEL=1 in shared package uart_pkg.
REQ-023 SHALL use one sub-module, sync2, for the two-flop synchronizer (parameterized reset value).

Verification
REQ-024 SHALL cover: CLK_DIV=16, send 8N1 0xA5 -> rx_byte=0xA5, with a single received pulse 153 cycles after the rxs falling edge.
REQ-025 SHALL cover: a 3-cycle low glitch on an idle line -> no received, no recv_error, is_receiving low again within 10 cycles.
REQ-026 SHALL cover: send 0x3C with stop bit=0, then hold rx low for 40 bit times -> one recv_error pulse, rx_byte keeps its prior value, and no new frame until rx goes high.
REQ-027 SHALL cover: back-to-back 0x00, 0xFF, 0x55 with no idle gap -> three received pulses and rx_byte values in that order.
REQ-028 SHALL cover: n_rst asserted in DATA bit 4 of a 0x81 frame -> all outputs reset immediately, and the next full frame 0x7E is received correctly.
REQ-029 SHALL cover: with UART_RX_PARITY_EN, send 0x07 with wrong parity (0) -> recv_error pulse, no received; with correct parity (1) -> rx_byte=0x07 after 169 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receive types and constants.
// UART_RX_PARITY_EN adds a PARITY state and an even-parity helper.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

`ifdef UART_RX_PARITY_EN
  function automatic logic even_par(
    input logic [DATA_BITS-1:0] d
  );
    return ^d;
  endfunction
`endif

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous bit.
// RST_VAL sets the level both flops hold in reset.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic q
);

  logic meta;

  // shift the raw input through two flops
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits, LSB first, one stop bit.
// Define UART_RX_PARITY_EN for an even-parity bit after the data.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 received,
  output logic                 is_receiving,
  output logic                 recv_error
);

  localparam logic [15:0] HALF = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLK_DIV - 1);
  localparam int          IW   = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);

  logic                 rxs;
  logic                 rxs_q;
  logic [1:0]           settle;
  logic                 fall;
  logic                 tick;
  state_t               state;
  logic [15:0]          cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;

  sync2 #(
    .RST_VAL (IDLE_LEVEL)
  ) u_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .d     (rx),
    .q     (rxs)
  );

  assign fall = rxs_q & ~rxs;
  assign tick = (cnt == 16'd0);

  // edge history; the reset level of the synchronizer
  // is not a real high, so wait until rxs carries rx
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      settle <= 2'b00;
      rxs_q  <= 1'b0;
    end else begin
      settle <= {settle[0], 1'b1};
      rxs_q  <= rxs & settle[1];
    end
  end

  // frame FSM with registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      cnt          <= 16'd0;
      idx          <= '0;
      shreg        <= '0;
      rx_byte      <= '0;
      received     <= 1'b0;
      recv_error   <= 1'b0;
      is_receiving <= 1'b0;
    end else begin
      received   <= 1'b0;
      recv_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fall) begin
            state        <= START;
            cnt          <= HALF;
            is_receiving <= 1'b1;
          end
        end
        START: begin
          if (!tick) begin
            cnt <= cnt - 16'd1;
          end else if (!rxs) begin
            state <= DATA;
            cnt   <= FULL;
            idx   <= '0;
          end else begin
            state        <= IDLE;
            is_receiving <= 1'b0;
          end
        end
        DATA: begin
          if (!tick) begin
            cnt <= cnt - 16'd1;
          end else begin
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
            cnt   <= FULL;
            idx   <= idx + 1'b1;
            if (idx == LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (!tick) begin
            cnt <= cnt - 16'd1;
          end else if (rxs != even_par(shreg)) begin
            recv_error <= 1'b1;
            state      <= WAIT_HIGH;
            cnt        <= 16'd0;
          end else begin
            state <= STOP;
            cnt   <= FULL;
          end
        end
`endif
        STOP: begin
          if (!tick) begin
            cnt <= cnt - 16'd1;
          end else if (rxs) begin
            rx_byte      <= shreg;
            received     <= 1'b1;
            state        <= IDLE;
            is_receiving <= 1'b0;
          end else begin
            recv_error <= 1'b1;
            state      <= WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (rxs) begin
            state        <= IDLE;
            is_receiving <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          is_receiving <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx.
// Define UART_RX_PARITY_EN to exercise the parity build.
module tb_uart_rx;

  localparam int CLK_DIV = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         due;
  } ev_t;

  logic       clk;
  logic       n_rst;
  logic       rx;
  logic [7:0] rx_byte;
  logic       received;
  logic       is_receiving;
  logic       recv_error;

  int         cyc;
  int         checks;
  int         failures;
  ev_t        q[$];
  ev_t        mon_e;
  logic [7:0] last_good;

  uart_rx #(
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .rx           (rx),
    .rx_byte      (rx_byte),
    .received     (received),
    .is_receiving (is_receiving),
    .recv_error   (recv_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (received && recv_error)
      chk("both_pulses", 1, 0);
    if (received || recv_error) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse",
            {received, recv_error}, 0);
      end else begin
        mon_e = q.pop_front();
        chk("event_kind", recv_error, mon_e.err);
        chk("event_cycle", cyc, mon_e.due);
        if (!mon_e.err) begin
          chk("rx_byte", rx_byte, mon_e.data);
          last_good = mon_e.data;
        end else begin
          chk("rx_byte_kept", rx_byte, last_good);
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CLK_DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input bit stop_bad,
                            input bit par_bad,
                            input int hold_bits);
    ev_t e;
    int  due;
    bit  pb;
    due = cyc + 2 + CLK_DIV / 2 + NBITS * CLK_DIV + 1;
    e.data = d;
    if (par_bad) begin
      e.err = 1'b1;
      e.due = due - CLK_DIV;
    end else begin
      e.err = stop_bad;
      e.due = due;
    end
    q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    pb = ($countones(d) % 2 == 1) ^ par_bad;
`ifdef UART_RX_PARITY_EN
    drive_bit(pb);
`endif
    drive_bit(!stop_bad);
    if (stop_bad) begin
      for (int i = 0; i < hold_bits; i++) drive_bit(1'b0);
      if (hold_bits > 0)
        chk("break_busy", is_receiving, 1);
      drive_bit(1'b1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    bit         sb;
    bit         pbad;
    int         c;
    checks    = 0;
    failures  = 0;
    last_good = 8'h00;
    n_rst     = 1'b0;
    rx        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rx_byte", rx_byte, 0);
    chk("rst_received", received, 0);
    chk("rst_error", recv_error, 0);
    chk("rst_busy", is_receiving, 0);
    n_rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("low_after_rst", is_receiving, 0);
    rx = 1'b1;
    repeat (2 * CLK_DIV) @(posedge clk);
    #1;

    send_frame(8'hA5, 0, 0, 0);
    repeat (CLK_DIV) @(posedge clk);
    #1;

    c  = cyc;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("glitch_start", is_receiving, 1);
    while (cyc < c + 13) begin
      @(posedge clk);
      #1;
    end
    chk("glitch_idle", is_receiving, 0);
    repeat (CLK_DIV) @(posedge clk);
    #1;

    send_frame(8'h3C, 1, 0, 40);
    chk("break_idle", is_receiving, 0);

    send_frame(8'h00, 0, 0, 0);
    send_frame(8'hFF, 0, 0, 0);
    send_frame(8'h55, 0, 0, 0);
    repeat (CLK_DIV) @(posedge clk);
    #1;

    d = 8'h81;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (CLK_DIV / 2) @(posedge clk);
    #1;
    chk("pre_rst_busy", is_receiving, 1);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_rx_byte", rx_byte, 0);
    chk("mid_rst_received", received, 0);
    chk("mid_rst_error", recv_error, 0);
    chk("mid_rst_busy", is_receiving, 0);
    last_good = 8'h00;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (CLK_DIV) @(posedge clk);
    #1;
    chk("post_rst_idle", is_receiving, 0);
    send_frame(8'h7E, 0, 0, 0);
    repeat (CLK_DIV) @(posedge clk);
    #1;

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 0, 1, 0);
    repeat (CLK_DIV) @(posedge clk);
    #1;
    send_frame(8'h07, 0, 0, 0);
    repeat (CLK_DIV) @(posedge clk);
    #1;
`endif

    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom_range(255, 0));
      sb   = ($urandom_range(4, 0) == 0);
      pbad = 1'b0;
`ifdef UART_RX_PARITY_EN
      if (!sb) pbad = ($urandom_range(4, 0) == 0);
`endif
      send_frame(d, sb, pbad, 0);
      repeat ($urandom_range(2 * CLK_DIV, 0))
        @(posedge clk);
      #1;
    end

    repeat (4 * CLK_DIV) @(posedge clk);
    #1;
    chk("pending_events", q.size(), 0);
    chk("final_idle", is_receiving, 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
